// File: rtl/model_out_buffer.sv
// Result FIFO between MODEL and its consumer: captures every valid beat, re-issues it over valid/ready, and flags dropped beats.
// Optional push counter on o_CNT when MODEL_OUT_BUF_CNT_EN is defined.
module model_out_buffer #(
    parameter int BITWIDTH = 32,
    parameter int NUM_OUT  = 2,
    parameter int DEPTH    = 8
) (
    input  logic                          i_CLK,
    input  logic                          i_nRST,
    input  logic [NUM_OUT*BITWIDTH-1:0]   i_DATA,
    input  logic                          i_VALID,
    output logic [NUM_OUT*BITWIDTH-1:0]   o_DATA,
    output logic                          o_VALID,
    input  logic                          i_READY,
    output logic [$clog2(DEPTH):0]        o_LEVEL,
    output logic                          o_FULL,
    output logic                          o_EMPTY,
    output logic                          o_OVERFLOW,
    input  logic                          i_CLR_OVF
`ifdef MODEL_OUT_BUF_CNT_EN
    ,
    output logic [31:0]                   o_CNT
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = NUM_OUT * BITWIDTH;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, drop;

`ifdef MODEL_OUT_BUF_CNT_EN
    logic [31:0]   cnt_q, cnt_d;
`endif

    always_comb begin
        pop      = !empty_q && i_READY;
        push     = i_VALID && (!full_q || pop);
        drop     = i_VALID && full_q && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + PW'(1);
        end else if (pop && !push) begin
            level_d = level_q - PW'(1);
        end
        full_d  = (level_d == PW'(DEPTH));
        empty_d = (level_d == '0);
        // A drop in the same cycle as a clear must leave the flag set.
        if (i_CLR_OVF) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

`ifdef MODEL_OUT_BUF_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (push) begin
            cnt_d = cnt_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge i_CLK) begin
        if (!i_nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef MODEL_OUT_BUF_CNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
`ifdef MODEL_OUT_BUF_CNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Storage has no reset; only accepted beats are written, so idle-cycle X on i_DATA never lands.
    always_ff @(posedge i_CLK) begin
        if (i_nRST && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_DATA;
        end
    end

    assign o_DATA     = mem_q[rd_ptr_q[AW-1:0]];
    assign o_VALID    = !empty_q;
    assign o_LEVEL    = level_q;
    assign o_FULL     = full_q;
    assign o_EMPTY    = empty_q;
    assign o_OVERFLOW = ovf_q;
`ifdef MODEL_OUT_BUF_CNT_EN
    assign o_CNT      = cnt_q;
`endif

endmodule

// File: tb/tb_model_out_buffer.sv
// Scoreboard bench for model_out_buffer: stimulus pushes expected beats, a negedge monitor checks status and pops on handshake.
module tb_model_out_buffer;

    localparam int BW    = 32;
    localparam int NO    = 2;
    localparam int DEPTH = 8;
    localparam int DW    = BW * NO;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          i_nRST;
    logic [DW-1:0] i_DATA;
    logic          i_VALID;
    logic [DW-1:0] o_DATA;
    logic          o_VALID;
    logic          i_READY;
    logic [LW-1:0] o_LEVEL;
    logic          o_FULL;
    logic          o_EMPTY;
    logic          o_OVERFLOW;
    logic          i_CLR_OVF;
`ifdef MODEL_OUT_BUF_CNT_EN
    logic [31:0]   o_CNT;
`endif

    always #5 clk = ~clk;

    model_out_buffer #(.BITWIDTH(BW), .NUM_OUT(NO), .DEPTH(DEPTH)) dut (
        .i_CLK      (clk),
        .i_nRST     (i_nRST),
        .i_DATA     (i_DATA),
        .i_VALID    (i_VALID),
        .o_DATA     (o_DATA),
        .o_VALID    (o_VALID),
        .i_READY    (i_READY),
        .o_LEVEL    (o_LEVEL),
        .o_FULL     (o_FULL),
        .o_EMPTY    (o_EMPTY),
        .o_OVERFLOW (o_OVERFLOW),
        .i_CLR_OVF  (i_CLR_OVF)
`ifdef MODEL_OUT_BUF_CNT_EN
        ,
        .o_CNT      (o_CNT)
`endif
    );

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q [$];
    int            m_level = 0;
    logic          m_ovf = 1'b0;
    logic [31:0]   m_cnt = '0;
    bit            chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: model state reflects the last edge; head is popped when the consumer handshakes.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_VALID", 64'(o_VALID), 64'(m_level > 0));
            chk("o_LEVEL", 64'(o_LEVEL), 64'(m_level));
            chk("o_FULL", 64'(o_FULL), 64'(m_level == DEPTH));
            chk("o_EMPTY", 64'(o_EMPTY), 64'(m_level == 0));
            chk("o_OVERFLOW", 64'(o_OVERFLOW), 64'(m_ovf));
`ifdef MODEL_OUT_BUF_CNT_EN
            chk("o_CNT", 64'(o_CNT), 64'(m_cnt));
`endif
            if (m_level > 0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got o_DATA %0h expected no entry", o_DATA);
                end else begin
                    chk("o_DATA", o_DATA, exp_q[0]);
                    if (i_READY && i_nRST) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        bit mpop, mpush, mdrop;
        i_VALID   = v;
        i_DATA    = v ? d : 'x;
        i_READY   = r;
        i_CLR_OVF = c;
        @(posedge clk);
        mpop  = (m_level > 0) && r;
        mpush = v && ((m_level < DEPTH) || mpop);
        mdrop = v && (m_level == DEPTH) && !mpop;
        if (mpush) begin
            exp_q.push_back(d);
            m_cnt = m_cnt + 32'd1;
        end
        m_level = m_level + int'(mpush) - int'(mpop);
        if (mdrop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        i_nRST    = 1'b0;
        i_VALID   = 1'b0;
        i_DATA    = '0;
        i_READY   = 1'b0;
        i_CLR_OVF = 1'b0;
        @(posedge clk);
        m_level = 0;
        m_ovf   = 1'b0;
        m_cnt   = '0;
        exp_q.delete();
        #1;
        i_nRST = 1'b1;
    endtask

    task automatic drain();
        for (int g = 0; g < 4 * DEPTH && m_level > 0; g++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;

        // idle after reset
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // single beat, consumer ready
        step(1'b1, 64'hA5A5_0001_A5A5_0001, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // fill 1..8 then beat 9 is dropped
        for (int i = 1; i <= 9; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // full with simultaneous push/pop, pointers wrap
        for (int i = 0; i < 20; i++) step(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0);
        drain();

        // backpressure with sparse input
        for (int k = 0; k < 200; k++) begin
            logic v, r;
            v = ($urandom_range(0, 99) < 40);
            r = 1'($urandom_range(0, 1));
            step(v, {32'hB000_0000 | 32'(k), ~32'(k)}, r, 1'b0);
        end
        drain();

        // reset mid-stream with level 5
        for (int i = 0; i < 5; i++) step(1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0);
        do_reset();
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 64'hD00D, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // clear concurrent with a drop keeps overflow set, then a lone clear drops it
        for (int i = 0; i < DEPTH; i++) step(1'b1, 64'hE0 + 64'(i), 1'b0, 1'b0);
        step(1'b1, 64'hEEEE, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
